// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scancode to ASCII translator with a show-ahead character FIFO; optional CAPS_LOCK_EN adds a caps-lock toggle on 58h.
// Latency: a mapped make code sampled at edge N is visible on ascii/ascii_valid after edge N.
// Backpressure: ascii_valid/ascii_ready drain; a character arriving at a full FIFO with no pop is dropped and overflow pulses.

module ps2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  input  logic             out_rdy,
  output logic             full,
  output logic             drop
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  assign out_vld = (count_q != '0);
  assign full    = (count_q == DEPTH[AW:0]);
  assign out_dat = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    pop      = out_vld && out_rdy;
    push     = in_vld && (!full || pop);
    drop     = in_vld && !push;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= in_dat;
    end
  end
endmodule

module ps2_ascii_decoder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       code_valid,
  input  logic [7:0] code,
  output logic       ascii_valid,
  output logic [7:0] ascii,
  input  logic       ascii_ready,
  output logic       fifo_full,
  output logic       overflow,
  output logic       shift_active
);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t     state_q, state_d;
  logic       shl_q, shl_d, shr_q, shr_d;
  logic       overflow_q;
  logic       upper, push_vld, drop;
  logic [7:0] push_dat;
  logic       letter_hit, digit_hit, map_hit;
  logic [4:0] letter_idx;
  logic [3:0] digit_idx;
  logic [7:0] map_chr;

  assign shift_active = shl_q | shr_q;
  assign overflow     = overflow_q;

`ifdef CAPS_LOCK_EN
  logic caps_q, caps_d;
  assign upper = shift_active ^ caps_q;
`else
  assign upper = shift_active;
`endif

  always_comb begin
    letter_hit = 1'b1;
    letter_idx = 5'd0;
    case (code)
      8'h1C: letter_idx = 5'd0;   8'h32: letter_idx = 5'd1;
      8'h21: letter_idx = 5'd2;   8'h23: letter_idx = 5'd3;
      8'h24: letter_idx = 5'd4;   8'h2B: letter_idx = 5'd5;
      8'h34: letter_idx = 5'd6;   8'h33: letter_idx = 5'd7;
      8'h43: letter_idx = 5'd8;   8'h3B: letter_idx = 5'd9;
      8'h42: letter_idx = 5'd10;  8'h4B: letter_idx = 5'd11;
      8'h3A: letter_idx = 5'd12;  8'h31: letter_idx = 5'd13;
      8'h44: letter_idx = 5'd14;  8'h4D: letter_idx = 5'd15;
      8'h15: letter_idx = 5'd16;  8'h2D: letter_idx = 5'd17;
      8'h1B: letter_idx = 5'd18;  8'h2C: letter_idx = 5'd19;
      8'h3C: letter_idx = 5'd20;  8'h2A: letter_idx = 5'd21;
      8'h1D: letter_idx = 5'd22;  8'h22: letter_idx = 5'd23;
      8'h35: letter_idx = 5'd24;  8'h1A: letter_idx = 5'd25;
      default: letter_hit = 1'b0;
    endcase

    digit_hit = 1'b1;
    digit_idx = 4'd0;
    case (code)
      8'h45: digit_idx = 4'd0;  8'h16: digit_idx = 4'd1;
      8'h1E: digit_idx = 4'd2;  8'h26: digit_idx = 4'd3;
      8'h25: digit_idx = 4'd4;  8'h2E: digit_idx = 4'd5;
      8'h36: digit_idx = 4'd6;  8'h3D: digit_idx = 4'd7;
      8'h3E: digit_idx = 4'd8;  8'h46: digit_idx = 4'd9;
      default: digit_hit = 1'b0;
    endcase
  end

  always_comb begin
    map_hit = 1'b1;
    map_chr = 8'h00;
    if (letter_hit) begin
      map_chr = (upper ? 8'h41 : 8'h61) + {3'b000, letter_idx};
    end else if (digit_hit && !shift_active) begin
      map_chr = 8'h30 + {4'b0000, digit_idx};
    end else if (digit_hit) begin
      case (digit_idx)
        4'd0:    map_chr = 8'h29;
        4'd1:    map_chr = 8'h21;
        4'd2:    map_chr = 8'h40;
        4'd3:    map_chr = 8'h23;
        4'd4:    map_chr = 8'h24;
        4'd5:    map_chr = 8'h25;
        4'd6:    map_chr = 8'h5E;
        4'd7:    map_chr = 8'h26;
        4'd8:    map_chr = 8'h2A;
        default: map_chr = 8'h28;
      endcase
    end else begin
      case (code)
        8'h29:   map_chr = 8'h20;
        8'h5A:   map_chr = 8'h0D;
        8'h66:   map_chr = 8'h08;
        default: map_hit = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    shl_d    = shl_q;
    shr_d    = shr_q;
    push_vld = 1'b0;
    push_dat = map_chr;
`ifdef CAPS_LOCK_EN
    caps_d   = caps_q;
`endif
    if (code_valid) begin
      case (state_q)
        IDLE: begin
          if (code == 8'hF0)      state_d = BRK;
          else if (code == 8'hE0) state_d = EXT;
          else if (code == 8'h12) shl_d   = 1'b1;
          else if (code == 8'h59) shr_d   = 1'b1;
`ifdef CAPS_LOCK_EN
          else if (code == 8'h58) caps_d  = ~caps_q;
`endif
          else                    push_vld = map_hit;
        end
        BRK: begin
          if (code == 8'h12) shl_d = 1'b0;
          if (code == 8'h59) shr_d = 1'b0;
          state_d = IDLE;
        end
        EXT:     state_d = (code == 8'hF0) ? EXT_BRK : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shl_q      <= 1'b0;
      shr_q      <= 1'b0;
      overflow_q <= 1'b0;
`ifdef CAPS_LOCK_EN
      caps_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shl_q      <= shl_d;
      shr_q      <= shr_d;
      overflow_q <= drop;
`ifdef CAPS_LOCK_EN
      caps_q     <= caps_d;
`endif
    end
  end

  ps2_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .AW    (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (push_vld),
    .in_dat  (push_dat),
    .out_vld (ascii_valid),
    .out_dat (ascii),
    .out_rdy (ascii_ready),
    .full    (fifo_full),
    .drop    (drop)
  );
endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench for ps2_ascii_decoder: queue-based reference model checked every cycle plus literal expectations per scenario.
module tb_ps2_ascii_decoder;
  localparam int DEPTH = 8;
`ifdef CAPS_LOCK_EN
  localparam bit CAPS_EN = 1'b1;
`else
  localparam bit CAPS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       code_valid = 1'b0;
  logic [7:0] code = 8'h00;
  logic       ascii_ready = 1'b0;
  logic       ascii_valid, fifo_full, overflow, shift_active;
  logic [7:0] ascii;

  ps2_ascii_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .code_valid   (code_valid),
    .code         (code),
    .ascii_valid  (ascii_valid),
    .ascii        (ascii),
    .ascii_ready  (ascii_ready),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .shift_active (shift_active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int ovf_seen = 0;
  logic [7:0] got[$];
  logic [7:0] exp[$];

  logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] sym_chars [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};

  // Reference model state: character queue, held keys and pending prefixes.
  logic [7:0] mq[$];
  bit m_shl, m_shr, m_caps, m_brk, m_ext, m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic lookup(input logic [7:0] c, input bit sh, input bit cp, output bit hit, output logic [7:0] ch);
    hit = 1'b0;
    ch  = 8'h00;
    for (int i = 0; i < 26; i++)
      if (let_codes[i] == c) begin
        hit = 1'b1;
        ch  = ((sh ^ cp) ? 8'h41 : 8'h61) + 8'(i);
      end
    for (int i = 0; i < 10; i++)
      if (dig_codes[i] == c) begin
        hit = 1'b1;
        ch  = sh ? sym_chars[i] : 8'h30 + 8'(i);
      end
    if (c == 8'h29) begin hit = 1'b1; ch = 8'h20; end
    if (c == 8'h5A) begin hit = 1'b1; ch = 8'h0D; end
    if (c == 8'h66) begin hit = 1'b1; ch = 8'h08; end
  endtask

  always @(posedge clk) begin : model
    bit pop, was_full, hit;
    logic [7:0] ch;
    if (rst) begin
      mq.delete();
      {m_shl, m_shr, m_caps, m_brk, m_ext, m_ovf} = '0;
    end else begin
      pop      = (mq.size() != 0) && ascii_ready;
      was_full = (mq.size() == DEPTH);
      hit      = 1'b0;
      ch       = 8'h00;
      m_ovf    = 1'b0;
      if (code_valid) begin
        if (m_brk) begin
          if (!m_ext && code == 8'h12) m_shl = 1'b0;
          if (!m_ext && code == 8'h59) m_shr = 1'b0;
          m_brk = 1'b0;
          m_ext = 1'b0;
        end else if (m_ext) begin
          if (code == 8'hF0) m_brk = 1'b1;
          else m_ext = 1'b0;
        end else if (code == 8'hF0) m_brk = 1'b1;
        else if (code == 8'hE0) m_ext = 1'b1;
        else if (code == 8'h12) m_shl = 1'b1;
        else if (code == 8'h59) m_shr = 1'b1;
        else if (CAPS_EN && code == 8'h58) m_caps = !m_caps;
        else lookup(code, m_shl | m_shr, m_caps, hit, ch);
      end
      if (pop) void'(mq.pop_front());
      if (hit) begin
        if (!was_full || pop) mq.push_back(ch);
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ascii_valid", ascii_valid, mq.size() != 0);
      if (mq.size() != 0) chk("ascii", ascii, mq[0]);
      chk("fifo_full", fifo_full, mq.size() == DEPTH);
      chk("overflow", overflow, m_ovf);
      chk("shift_active", shift_active, m_shl | m_shr);
      if (ascii_valid && ascii_ready) got.push_back(ascii);
      if (overflow) ovf_seen++;
    end
  end

  task automatic send(input logic [7:0] c);
    code_valid = 1'b1;
    code       = c;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_got(input string name);
    chk({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) chk(name, got[i], exp[i]);
    got.delete();
    exp.delete();
  endtask

  initial begin
    idle(2);
    cmp_en = 1'b1;
    chk("rst_valid", ascii_valid, 0);
    chk("rst_ascii", ascii, 8'h00);
    chk("rst_full", fifo_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_shift", shift_active, 0);
    rst = 1'b0;
    got.delete();

    // Make/break of a single letter.
    ascii_ready = 1'b1;
    send(8'h1C);
    chk("lat_valid", ascii_valid, 1);
    chk("lat_ascii", ascii, 8'h61);
    send(8'hF0);
    send(8'h1C);
    idle(3);
    exp = '{8'h61};
    check_got("make_break");

    // Shift held around a letter.
    send(8'h12);
    chk("shift_set", shift_active, 1);
    send(8'h32);
    send(8'hF0);
    chk("shift_hold", shift_active, 1);
    send(8'h12);
    chk("shift_clr", shift_active, 0);
    send(8'h32);
    idle(3);
    exp = '{8'h42, 8'h62};
    check_got("shift");

    // Typematic, shifted digits, control keys, unmapped code.
    foreach (exp[i]) exp.delete();
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'h59); send(8'h16); send(8'h45); send(8'hF0); send(8'h59);
    send(8'h5A); send(8'h66); send(8'h76); send(8'h29);
    idle(3);
    exp = '{8'h61, 8'h61, 8'h61, 8'h21, 8'h29, 8'h0D, 8'h08, 8'h20};
    check_got("misc");

    // Overfill with no drain, then drain.
    ascii_ready = 1'b0;
    ovf_seen    = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      send(dig_codes[(i + 1) % 10]);
      if (i == DEPTH - 2) chk("not_full_7", fifo_full, 0);
      if (i == DEPTH - 1) chk("full_8", fifo_full, 1);
    end
    idle(1);
    chk("ovf_pulses", ovf_seen, 2);
    ascii_ready = 1'b1;
    idle(DEPTH + 2);
    for (int i = 0; i < DEPTH; i++) exp.push_back(8'h31 + 8'(i));
    check_got("overfill");

    // Refill after wrap; push into a full FIFO while it pops.
    ascii_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(let_codes[i]);
    chk("refill_full", fifo_full, 1);
    ascii_ready = 1'b1;
    send(let_codes[DEPTH]);
    chk("full_pop_ovf", overflow, 0);
    chk("full_pop_full", fifo_full, 1);
    idle(DEPTH + 4);
    for (int i = 0; i <= DEPTH; i++) exp.push_back(8'h61 + 8'(i));
    check_got("wrap");

    // Extended keys ignored.
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h29);
    idle(3);
    exp = '{8'h20};
    check_got("extended");

    // Reset discards a pending break prefix, shift state and a same-edge code.
    send(8'h12);
    send(8'hF0);
    rst        = 1'b1;
    code_valid = 1'b1;
    code       = 8'h1C;
    idle(1);
    rst        = 1'b0;
    code_valid = 1'b0;
    chk("rst_mid_shift", shift_active, 0);
    chk("rst_mid_valid", ascii_valid, 0);
    send(8'h1C);
    idle(3);
    exp = '{8'h61};
    check_got("rst_mid");

    // Caps lock.
    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12);
    idle(3);
    if (CAPS_EN) exp = '{8'h41, 8'h61};
    else exp = '{8'h61, 8'h41};
    check_got("caps");

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
